// File: rtl/ex_stage_md_if.sv
// ID/EX inputs, forwarding sources and EX/MEM outputs of the execute stage.
interface ex_stage_md_if #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
);
  logic            id_valid;
  logic            flush;
  logic [3:0]      alu_op;
  logic            alu_src1;
  logic            alu_src2;
  logic [2:0]      md_op;
  logic [1:0]      reg_dst;
  logic [4:0]      shamt;
  logic [XLEN-1:0] imm;
  logic [RAW-1:0]  rs;
  logic [RAW-1:0]  rt;
  logic [RAW-1:0]  rd;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic            mem_wr;
  logic            mem_rd;
  logic            reg_wr;
  logic [1:0]      mem_to_reg;
  logic [XLEN-1:0] pc_plus4;
  logic            mem_reg_wr;
  logic            wb_reg_wr;
  logic [RAW-1:0]  mem_wreg;
  logic [RAW-1:0]  wb_wreg;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] wb_wdata;
  logic            ex_stall;
  logic [RAW-1:0]  ex_wreg;
  logic            xm_valid;
  logic            xm_mem_wr;
  logic            xm_mem_rd;
  logic            xm_reg_wr;
  logic [1:0]      xm_mem_to_reg;
  logic [RAW-1:0]  xm_wreg;
  logic [XLEN-1:0] xm_alu;
  logic [XLEN-1:0] xm_store;
  logic [XLEN-1:0] xm_pc4;

  modport master (
    output id_valid, flush, alu_op, alu_src1, alu_src2, md_op, reg_dst, shamt, imm,
           rs, rt, rd, rs_data, rt_data, mem_wr, mem_rd, reg_wr, mem_to_reg, pc_plus4,
           mem_reg_wr, wb_reg_wr, mem_wreg, wb_wreg, mem_wdata, wb_wdata,
    input  ex_stall, ex_wreg, xm_valid, xm_mem_wr, xm_mem_rd, xm_reg_wr, xm_mem_to_reg,
           xm_wreg, xm_alu, xm_store, xm_pc4
  );

  modport slave (
    input  id_valid, flush, alu_op, alu_src1, alu_src2, md_op, reg_dst, shamt, imm,
           rs, rt, rd, rs_data, rt_data, mem_wr, mem_rd, reg_wr, mem_to_reg, pc_plus4,
           mem_reg_wr, wb_reg_wr, mem_wreg, wb_wreg, mem_wdata, wb_wdata,
    output ex_stall, ex_wreg, xm_valid, xm_mem_wr, xm_mem_rd, xm_reg_wr, xm_mem_to_reg,
           xm_wreg, xm_alu, xm_store, xm_pc4
  );
endinterface

// File: rtl/ex_stage_md.sv
// Execute stage: operand forwarding, ALU, destination select, EX/MEM register,
// plus an iterative multiply/divide unit with HI/LO.
//   state | meaning
//   IDLE  | no mul/div in flight; mfhi/mflo may read HI/LO
//   BUSY  | one shift-add / restoring-divide step per cycle
//   DONE  | result ready, HI/LO written at the end of this cycle
module ex_stage_md #(
  parameter int XLEN     = 32,
  parameter int RAW      = 5,
  parameter int FAST_MUL = 0
) (
  input logic          clk,
  input logic          rst_n,
  ex_stage_md_if.slave bus
);
  localparam int SW = $clog2(XLEN);
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;

  logic [XLEN-1:0]   op_a, op_b, op1, op2, alu_res, result;
  logic [SW-1:0]     amt;
  logic              is_md, is_mf, sgn_c, div_c, a_neg, b_neg, start, xm_valid_nx;
  logic [XLEN-1:0]   mag_a, mag_bc;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN:0]     mul_sum, div_shl, div_diff;
  logic [XLEN-1:0]   q_fix, r_fix;
  logic [RAW-1:0]    wreg;

  logic [CW-1:0]     count;
  logic [XLEN-1:0]   acc_hi, acc_lo, mag_b, dvd, hi, lo;
  logic              mdiv, div_zero, neg_q, neg_r;

  logic              xm_valid, xm_mem_wr, xm_mem_rd, xm_reg_wr;
  logic [1:0]        xm_mem_to_reg;
  logic [RAW-1:0]    xm_wreg;
  logic [XLEN-1:0]   xm_alu, xm_store, xm_pc4;

  // MEM wins over WB; r0 is never forwarded
  always_comb begin
    op_a = bus.rs_data;
    if (bus.wb_reg_wr && bus.wb_wreg != '0 && bus.wb_wreg == bus.rs) op_a = bus.wb_wdata;
    if (bus.mem_reg_wr && bus.mem_wreg != '0 && bus.mem_wreg == bus.rs) op_a = bus.mem_wdata;
    op_b = bus.rt_data;
    if (bus.wb_reg_wr && bus.wb_wreg != '0 && bus.wb_wreg == bus.rt) op_b = bus.wb_wdata;
    if (bus.mem_reg_wr && bus.mem_wreg != '0 && bus.mem_wreg == bus.rt) op_b = bus.mem_wdata;
  end

  assign op1 = bus.alu_src1 ? {{(XLEN-5){1'b0}}, bus.shamt} : op_a;
  assign op2 = bus.alu_src2 ? bus.imm : op_b;
  assign amt = op1[SW-1:0];

  always_comb begin
    alu_res = '0;
    case (bus.alu_op)
      4'd0:    alu_res = op1 + op2;
      4'd1:    alu_res = op1 - op2;
      4'd2:    alu_res = op1 & op2;
      4'd3:    alu_res = op1 | op2;
      4'd4:    alu_res = op1 ^ op2;
      4'd5:    alu_res = ~(op1 | op2);
      4'd6:    alu_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
      4'd7:    alu_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
      4'd8:    alu_res = op2 << amt;
      4'd9:    alu_res = op2 >> amt;
      4'd10:   alu_res = XLEN'($signed(op2) >>> amt);
      4'd11:   alu_res = op2;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    wreg = bus.rt;
    case (bus.reg_dst)
      2'b00:   wreg = bus.rt;
      2'b01:   wreg = bus.rd;
      2'b10:   wreg = '1;
      default: wreg = RAW'(2**RAW - 6);
    endcase
  end
  assign bus.ex_wreg = wreg;

  assign is_md  = (bus.md_op >= 3'd1) && (bus.md_op <= 3'd4);
  assign is_mf  = (bus.md_op == 3'd5) || (bus.md_op == 3'd6);
  assign sgn_c  = (bus.md_op == 3'd1) || (bus.md_op == 3'd3);
  assign div_c  = (bus.md_op == 3'd3) || (bus.md_op == 3'd4);
  assign a_neg  = sgn_c && op_a[XLEN-1];
  assign b_neg  = sgn_c && op_b[XLEN-1];
  assign mag_a  = a_neg ? -op_a : op_a;
  assign mag_bc = b_neg ? -op_b : op_b;
  assign prod   = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_bc};

  assign bus.ex_stall = bus.id_valid &&
                        ((is_md && state != DONE) || (is_mf && state != IDLE));

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    case (state)
      IDLE: if (bus.id_valid && is_md && !bus.flush) begin
        start    = 1'b1;
        state_nx = (FAST_MUL != 0 && !div_c) ? DONE : BUSY;
      end
      BUSY:    if (count == CW'(1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.flush) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Iterations run on magnitudes; signs are applied when HI/LO are written
  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
  assign div_shl  = {acc_hi, acc_lo[XLEN-1]};
  assign div_diff = div_shl - {1'b0, mag_b};
  assign prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign q_fix    = neg_q ? -acc_lo : acc_lo;
  assign r_fix    = neg_r ? -acc_hi : acc_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      mag_b    <= '0;
      dvd      <= '0;
      mdiv     <= 1'b0;
      div_zero <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else if (bus.flush) begin
      count <= '0;
    end else if (start) begin
      mag_b    <= mag_bc;
      dvd      <= op_a;
      mdiv     <= div_c;
      div_zero <= (op_b == '0);
      neg_q    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
      if (FAST_MUL != 0 && !div_c) begin
        {acc_hi, acc_lo} <= prod;
        count            <= '0;
      end else begin
        acc_hi <= '0;
        acc_lo <= mag_a;
        count  <= CW'(XLEN);
      end
    end else if (state == BUSY) begin
      count <= count - CW'(1);
      if (!mdiv) begin
        acc_hi <= mul_sum[XLEN:1];
        acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
      end else if (!div_diff[XLEN]) begin
        acc_hi <= div_diff[XLEN-1:0];
        acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
      end else begin
        acc_hi <= div_shl[XLEN-1:0];
        acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
      end
    end else if (state == DONE) begin
      if (!mdiv) begin
        {hi, lo} <= prod_fix;
      end else if (div_zero) begin
        hi <= dvd;
        lo <= '1;
      end else begin
        hi <= r_fix;
        lo <= q_fix;
      end
    end
  end

  assign result      = is_mf ? ((bus.md_op == 3'd5) ? hi : lo) : alu_res;
  assign xm_valid_nx = bus.id_valid && !bus.ex_stall && !bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xm_valid      <= 1'b0;
      xm_mem_wr     <= 1'b0;
      xm_mem_rd     <= 1'b0;
      xm_reg_wr     <= 1'b0;
      xm_mem_to_reg <= '0;
      xm_wreg       <= '0;
      xm_alu        <= '0;
      xm_store      <= '0;
      xm_pc4        <= '0;
    end else begin
      xm_valid      <= xm_valid_nx;
      xm_mem_wr     <= xm_valid_nx && bus.mem_wr;
      xm_mem_rd     <= xm_valid_nx && bus.mem_rd;
      xm_reg_wr     <= xm_valid_nx && bus.reg_wr && !is_md;
      xm_mem_to_reg <= bus.mem_to_reg;
      xm_wreg       <= wreg;
      xm_alu        <= result;
      xm_store      <= op_b;
      xm_pc4        <= bus.pc_plus4;
    end
  end

  assign bus.xm_valid      = xm_valid;
  assign bus.xm_mem_wr     = xm_mem_wr;
  assign bus.xm_mem_rd     = xm_mem_rd;
  assign bus.xm_reg_wr     = xm_reg_wr;
  assign bus.xm_mem_to_reg = xm_mem_to_reg;
  assign bus.xm_wreg       = xm_wreg;
  assign bus.xm_alu        = xm_alu;
  assign bus.xm_store      = xm_store;
  assign bus.xm_pc4        = xm_pc4;
endmodule
